// File: rtl/spi_sub_sync.sv
// SPI mode-0 subordinate that samples sclk/cs_n/mosi into the clk domain
// and moves fixed WIDTH-bit frames MSB first in both directions.
//
// state | meaning
// IDLE  | no frame, miso 0, waiting for cs_n to fall
// SHIFT | frame in progress, bits moving on sclk edges
// DONE  | WIDTH bits taken; publish rx word once, wait for cs_n to rise
module spi_sub_sync #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             aborted
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [2:0]       sclk_q;
    logic [2:0]       cs_q;
    logic [1:0]       mosi_q;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [CW-1:0]    cnt;
    logic             rx_pend;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic last_rise;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign last_rise = sclk_rise && (cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf <= '0;
        end else if (tx_load) begin
            tx_buf <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cnt      <= '0;
            rx_pend  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b0;
            miso     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            aborted  <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    busy <= 1'b0;
                    if (cs_fall) begin
                        state <= SHIFT;
                        tx_sh <= tx_buf;
                        cnt   <= '0;
                        miso  <= tx_buf[WIDTH-1];
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // a final bit landing with cs_n rising still completes the frame
                    if (cs_rise && !last_rise) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        miso    <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[WIDTH-2:0], mosi_q[1]};
                        cnt   <= cnt + 1'b1;
                        if (last_rise) begin
                            state   <= DONE;
                            rx_pend <= 1'b1;
                            miso    <= 1'b0;
                        end
                    end else if (sclk_fall && (cnt != '0) && (cnt <= LAST_BIT)) begin
                        tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
                        miso  <= tx_sh[WIDTH-2];
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (rx_pend) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        rx_pend  <= 1'b0;
                    end
                    if (cs_q[1]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    miso  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sub_sync.sv
// Directed bench for spi_sub_sync: an SPI main model drives frames from a
// vector table, then a hand sequence covers reset in the middle of a frame.
module tb_spi_sub_sync;

    localparam int W = 128;

    logic         clk;
    logic         rst_n;
    logic         cs_n;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_load;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         aborted;

    int n_vec;
    int n_bad;
    int n_valid;
    int n_abort;

    spi_sub_sync #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .aborted  (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) n_valid <= n_valid + 1;
        if (aborted)  n_abort <= n_abort + 1;
    end

    typedef struct {
        logic         pre_load;
        logic [W-1:0] pre_word;
        int           load_bit;
        logic [W-1:0] load_word;
        logic [W-1:0] mosi_word;
        int           nbits;
        logic         extra_mosi;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_rx;
        int           exp_valid;
        int           exp_abort;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [W-1:0] w);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    // One frame from the main's side; the main samples miso at each sclk rise.
    task automatic run_frame(input logic [W-1:0] mosi_word, input int nbits,
                             input logic extra_mosi, input int load_bit,
                             input logic [W-1:0] load_word, input int rst_bit,
                             output logic [W-1:0] miso_word, output logic miso_extra,
                             output logic busy_end);
        miso_word  = '0;
        miso_extra = 1'b0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < W) ? mosi_word[W-1-i] : extra_mosi;
            if (i == load_bit) load_tx(load_word);
            if (i == rst_bit) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check("rst miso", W'(miso), '0);
                check("rst busy", W'(busy), '0);
                check("rst rx_valid", W'(rx_valid), '0);
                check("rst aborted", W'(aborted), '0);
                check("rst rx_data", rx_data, '0);
                rst_n = 1'b1;
            end
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            if (i < W) miso_word = {miso_word[W-2:0], miso};
            else       miso_extra = miso_extra | miso;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        busy_end = busy;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    logic [W-1:0] got_miso;
    logic         got_extra;
    logic         got_busy;

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        n_valid = 0;
        n_abort = 0;
        rst_n   = 1'b0;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tx_data = '0;
        tx_load = 1'b0;

        vecs[0] = '{1'b0, '0, -1, '0, 128'habde1, 128, 1'b0,
                    '0, 128'habde1, 1, 0};
        vecs[1] = '{1'b1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, -1, '0,
                    128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 128, 1'b0,
                    128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210,
                    128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1, 0};
        vecs[2] = '{1'b0, '0, -1, '0,
                    128'hdead_beef_cafe_f00d_1234_5678_9abc_def0, 64, 1'b0,
                    128'h0123_4567_89ab_cdef,
                    128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 0, 1};
        vecs[3] = '{1'b1, {W{1'b1}}, -1, '0,
                    128'h8765_4321_0fed_cba9_1357_9bdf_2468_ace0, 130, 1'b1,
                    {W{1'b1}}, 128'h8765_4321_0fed_cba9_1357_9bdf_2468_ace0, 1, 0};
        vecs[4] = '{1'b0, '0, 40, 128'hfa4d, 128'h1, 128, 1'b0,
                    {W{1'b1}}, 128'h1, 1, 0};
        vecs[5] = '{1'b0, '0, -1, '0,
                    128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3, 128, 1'b0,
                    128'hfa4d, 128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3, 1, 0};

        repeat (5) @(negedge clk);
        check("reset miso", W'(miso), '0);
        check("reset busy", W'(busy), '0);
        check("reset rx_valid", W'(rx_valid), '0);
        check("reset aborted", W'(aborted), '0);
        check("reset rx_data", rx_data, '0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            if (vecs[k].pre_load) load_tx(vecs[k].pre_word);
            n_valid = 0;
            n_abort = 0;
            run_frame(vecs[k].mosi_word, vecs[k].nbits, vecs[k].extra_mosi,
                      vecs[k].load_bit, vecs[k].load_word, -1,
                      got_miso, got_extra, got_busy);
            check($sformatf("v%0d miso word", k), got_miso, vecs[k].exp_miso);
            check($sformatf("v%0d rx_data", k), rx_data, vecs[k].exp_rx);
            check($sformatf("v%0d rx_valid count", k), W'(n_valid), W'(vecs[k].exp_valid));
            check($sformatf("v%0d aborted count", k), W'(n_abort), W'(vecs[k].exp_abort));
            check($sformatf("v%0d busy before cs rise", k), W'(got_busy), W'(1));
            check($sformatf("v%0d busy after frame", k), W'(busy), '0);
            if (vecs[k].nbits > W)
                check($sformatf("v%0d miso past last bit", k), W'(got_extra), '0);
        end

        // reset at bit 70: stale frame ignored, then a clean frame
        n_valid = 0;
        n_abort = 0;
        run_frame(128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100, 128, 1'b0,
                  -1, '0, 70, got_miso, got_extra, got_busy);
        check("stale busy", W'(got_busy), '0);
        check("stale rx_valid count", W'(n_valid), '0);
        check("stale aborted count", W'(n_abort), '0);
        check("stale rx_data", rx_data, '0);

        n_valid = 0;
        run_frame(128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0, 128, 1'b0,
                  -1, '0, -1, got_miso, got_extra, got_busy);
        check("post-reset miso word", got_miso, '0);
        check("post-reset rx_data", rx_data, 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0);
        check("post-reset rx_valid count", W'(n_valid), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
